// File: rtl/fadsu_seq_pkg.sv
// -----------------------------------------------------------------------------
// fadsu_seq_pkg
// Shared types, sizes and byte helpers for the fadsu_seq multi-byte add/sub
// sequencer and its round-robin arbiter.
//   state_t  : sequencer FSM states (IDLE, RUN, FIN)
//   NBYTES   : bytes per operand word
//   LEN_W    : width of the "byte count minus 1" field
//   WORD     : operand / result width in bits
//   BYTE_W   : width of one slice handled by the external cell
// -----------------------------------------------------------------------------
package fadsu_seq_pkg;

    localparam int NBYTES = 4;
    localparam int LEN_W  = 2;
    localparam int WORD   = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Extract byte idx (LSB first) from a word.
    function automatic logic [BYTE_W-1:0] get_byte(
        input logic [WORD-1:0]  word,
        input logic [LEN_W-1:0] idx
    );
        logic [4:0] lsb;
        lsb = {idx, 3'b000};
        return word[lsb +: BYTE_W];
    endfunction

    // Return word with byte idx replaced by b.
    function automatic logic [WORD-1:0] put_byte(
        input logic [WORD-1:0]   word,
        input logic [LEN_W-1:0]  idx,
        input logic [BYTE_W-1:0] b
    );
        logic [WORD-1:0] r;
        logic [4:0]      lsb;
        r   = word;
        lsb = {idx, 3'b000};
        r[lsb +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/fadsu_seq_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a grant enable.
//   i_clk   : clock (rising edge)
//   i_rst   : synchronous active-high reset, pointer favours requester 0
//   i_en    : grants are only issued while high
//   i_req   : request vector, bit n = requester n
//   o_gnt   : one-hot (or zero) grant, combinational from i_req / i_en
// After any grant the pointer favours the other requester on the next tie.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 1 = requester 1 wins a tie, 0 = requester 0 wins a tie
    logic r_ptr;

    // Grant selection: lone requester wins, ties go to the favoured side
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end else begin
            o_gnt = 2'b00;
        end
    end

    // Tie pointer: flips to the loser of each issued grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (o_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (o_gnt[1]) begin
            r_ptr <= 1'b0;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/fadsu_seq.sv
// -----------------------------------------------------------------------------
// fadsu_seq
// Two-requester sequencer that performs a 1..4 byte add or subtract by
// stepping an external 8-bit add/sub cell one byte per cycle, LSB first,
// chaining the carry through a register.
//   i_ck, i_cd           : clock, synchronous active-high reset
//   i_reqN/i_conN/i_bciN : request (level), op (1=add), initial carry-in
//   i_lenN               : byte count minus 1
//   i_opaN, i_opbN       : 32-bit operands
//   o_gntN               : one-cycle accept pulse (only while IDLE)
//   o_add_a/b/bci/con    : drive to the cell (zero outside RUN)
//   i_add_s, i_add_bco   : combinational return from the cell
//   o_busy               : not IDLE
//   o_done, o_done_id    : one-cycle completion pulse in FIN, winner id
//   o_res, o_bco         : result word and final carry, held until next FIN
// Timing: grant in cycle T, RUN cycles T+1..T+1+LEN, FIN (DONE) at T+LEN+2.
// -----------------------------------------------------------------------------
module fadsu_seq
    import fadsu_seq_pkg::*;
(
    input  logic              i_ck,
    input  logic              i_cd,
    input  logic              i_req0,
    input  logic              i_con0,
    input  logic              i_bci0,
    input  logic [LEN_W-1:0]  i_len0,
    input  logic [WORD-1:0]   i_opa0,
    input  logic [WORD-1:0]   i_opb0,
    output logic              o_gnt0,
    input  logic              i_req1,
    input  logic              i_con1,
    input  logic              i_bci1,
    input  logic [LEN_W-1:0]  i_len1,
    input  logic [WORD-1:0]   i_opa1,
    input  logic [WORD-1:0]   i_opb1,
    output logic              o_gnt1,
    output logic [BYTE_W-1:0] o_add_a,
    output logic [BYTE_W-1:0] o_add_b,
    output logic              o_add_bci,
    output logic              o_add_con,
    input  logic [BYTE_W-1:0] i_add_s,
    input  logic              i_add_bco,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_done_id,
    output logic [WORD-1:0]   o_res,
    output logic              o_bco
);

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_idx;
    logic               r_con;
    logic               r_bci;
    logic [LEN_W-1:0]   r_len;
    logic [WORD-1:0]    r_opa;
    logic [WORD-1:0]    r_opb;
    logic               r_id;
    logic [WORD-1:0]    r_acc;
    logic               r_carry;
    logic [WORD-1:0]    r_res;
    logic               r_bco;
    logic               r_done_id;

    logic [1:0]         w_gnt;
    logic               w_arb_en;
    logic               w_last;
    logic [WORD-1:0]    w_acc_next;

    // Arbitration is held off during reset so no grant escapes an abort cycle.
    assign w_arb_en = (r_state == ST_IDLE) && !i_cd;

    rr_arb2 u_arb (
        .i_clk (i_ck),
        .i_rst (i_cd),
        .i_en  (w_arb_en),
        .i_req ({i_req1, i_req0}),
        .o_gnt (w_gnt)
    );

    assign o_gnt0     = w_gnt[0];
    assign o_gnt1     = w_gnt[1];
    assign w_last     = (r_idx == r_len);
    assign w_acc_next = put_byte(r_acc, r_idx, i_add_s);

    assign o_res      = r_res;
    assign o_bco      = r_bco;
    assign o_done_id  = r_done_id;

    // FSM state register
    always_ff @(posedge i_ck) begin
        if (i_cd) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and cell / status outputs
    always_comb begin
        w_next_state = r_state;
        o_add_a      = {BYTE_W{1'b0}};
        o_add_b      = {BYTE_W{1'b0}};
        o_add_bci    = 1'b0;
        o_add_con    = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        // DONE is suppressed by a reset arriving in FIN itself
        o_done       = (r_state == ST_FIN) && !i_cd;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                o_add_a   = get_byte(r_opa, r_idx);
                o_add_b   = get_byte(r_opb, r_idx);
                o_add_con = r_con;
                // First byte takes the requester's carry-in, later bytes chain
                if (r_idx == {LEN_W{1'b0}}) begin
                    o_add_bci = r_bci;
                end else begin
                    o_add_bci = r_carry;
                end
                if (w_last) begin
                    w_next_state = ST_FIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch winner at grant, accumulate bytes in RUN, publish on last byte
    always_ff @(posedge i_ck) begin
        if (i_cd) begin
            r_idx     <= {LEN_W{1'b0}};
            r_con     <= 1'b0;
            r_bci     <= 1'b0;
            r_len     <= {LEN_W{1'b0}};
            r_opa     <= {WORD{1'b0}};
            r_opb     <= {WORD{1'b0}};
            r_id      <= 1'b0;
            r_acc     <= {WORD{1'b0}};
            r_carry   <= 1'b0;
            r_res     <= {WORD{1'b0}};
            r_bco     <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_id    <= w_gnt[1];
                        r_con   <= w_gnt[1] ? i_con1 : i_con0;
                        r_bci   <= w_gnt[1] ? i_bci1 : i_bci0;
                        r_len   <= w_gnt[1] ? i_len1 : i_len0;
                        r_opa   <= w_gnt[1] ? i_opa1 : i_opa0;
                        r_opb   <= w_gnt[1] ? i_opb1 : i_opb0;
                        r_idx   <= {LEN_W{1'b0}};
                        r_carry <= 1'b0;
                        // Clearing the whole accumulator leaves bytes above LEN at zero
                        r_acc   <= {WORD{1'b0}};
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= i_add_bco;
                    r_idx   <= r_idx + {{(LEN_W-1){1'b0}}, 1'b1};
                    // Visible result only changes here, so it stays stable between FINs
                    if (w_last) begin
                        r_res     <= w_acc_next;
                        r_bco     <= i_add_bco;
                        r_done_id <= r_id;
                    end
                end
                ST_FIN: begin
                    r_idx <= {LEN_W{1'b0}};
                end
                default: begin
                    r_idx <= {LEN_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fadsu_seq.sv
// -----------------------------------------------------------------------------
// tb_fadsu_seq
// Directed stimulus with hand-computed results; expected completions are
// queued at grant time and checked by an independent DONE monitor.
// -----------------------------------------------------------------------------
module tb_fadsu_seq;

    logic        ck = 1'b0;
    logic        cd = 1'b1;
    logic        req0 = 1'b0, con0 = 1'b0, bci0 = 1'b0;
    logic [1:0]  len0 = 2'd0;
    logic [31:0] opa0 = 32'd0, opb0 = 32'd0;
    logic        gnt0;
    logic        req1 = 1'b0, con1 = 1'b0, bci1 = 1'b0;
    logic [1:0]  len1 = 2'd0;
    logic [31:0] opa1 = 32'd0, opb1 = 32'd0;
    logic        gnt1;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_bci, add_con, add_bco;
    logic        busy, done, done_id, bco;
    logic [31:0] res;
    logic [8:0]  cell_sum;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        bco;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    // Behavioural model of the external 8-bit add/sub cell
    always_comb begin
        if (add_con) cell_sum = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_bci};
        else         cell_sum = {1'b0, add_a} + {1'b0, ~add_b} + {8'd0, add_bci};
    end
    assign add_s   = cell_sum[7:0];
    assign add_bco = cell_sum[8];

    fadsu_seq dut (
        .i_ck(ck), .i_cd(cd),
        .i_req0(req0), .i_con0(con0), .i_bci0(bci0), .i_len0(len0),
        .i_opa0(opa0), .i_opb0(opb0), .o_gnt0(gnt0),
        .i_req1(req1), .i_con1(con1), .i_bci1(bci1), .i_len1(len1),
        .i_opa1(opa1), .i_opb1(opb1), .o_gnt1(gnt1),
        .o_add_a(add_a), .o_add_b(add_b), .o_add_bci(add_bci), .o_add_con(add_con),
        .i_add_s(add_s), .i_add_bco(add_bco),
        .o_busy(busy), .o_done(done), .o_done_id(done_id), .o_res(res), .o_bco(bco)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [31:0] r, input logic b, input int c);
        exp_t e;
        e.id  = id;
        e.res = r;
        e.bco = b;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: grant legality every cycle, scoreboard compare on DONE
    always @(negedge ck) begin
        if (gnt0 || gnt1) begin
            check("gnt_both", 32'(gnt0 & gnt1), 32'd0);
            check("gnt_busy", 32'(busy), 32'd0);
        end
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DONE id=%0d res=0x%0h required no DONE", done_id, res);
            end else begin
                mon_e = sb.pop_front();
                check("done_res", res, mon_e.res);
                check("done_bco", 32'(bco), 32'(mon_e.bco));
                check("done_id", 32'(done_id), 32'(mon_e.id));
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge ck);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d pending required 0", sb.size());
            sb.delete();
        end
        @(posedge ck);
        #1;
    endtask

    // One request: wait for its grant, queue the result, check per-byte cell drive
    task automatic do_op(input logic n, input logic con, input logic bci, input logic [1:0] len,
                         input logic [31:0] opa, input logic [31:0] opb,
                         input logic [31:0] exp_res, input logic exp_bco, input logic [3:0] exp_bci);
        bit got;
        int t;
        if (n == 1'b0) begin
            con0 = con; bci0 = bci; len0 = len; opa0 = opa; opb0 = opb; req0 = 1'b1;
        end else begin
            con1 = con; bci1 = bci; len1 = len; opa1 = opa; opb1 = opb; req1 = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge ck);
            if ((n == 1'b0 && gnt0) || (n == 1'b1 && gnt1)) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no GNT%0d required GNT%0d", n, n);
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
        t = cyc;
        check("idle_add_a", 32'(add_a), 32'd0);
        check("idle_add_ctl", 32'({add_bci, add_con}), 32'd0);
        push_exp(n, exp_res, exp_bco, t + int'(len) + 2);
        @(posedge ck);
        #1;
        // Drop the request and disturb operands: the latched copy must be used
        if (n == 1'b0) begin
            req0 = 1'b0; con0 = ~con; bci0 = ~bci; len0 = ~len; opa0 = ~opa; opb0 = ~opb;
        end else begin
            req1 = 1'b0; con1 = ~con; bci1 = ~bci; len1 = ~len; opa1 = ~opa; opb1 = ~opb;
        end
        for (int k = 0; k <= int'(len); k++) begin
            @(negedge ck);
            check("run_add_a", 32'(add_a), (opa >> (8 * k)) & 32'h0000_00FF);
            check("run_add_b", 32'(add_b), (opb >> (8 * k)) & 32'h0000_00FF);
            check("run_add_con", 32'(add_con), 32'(con));
            check("run_add_bci", 32'(add_bci), 32'(exp_bci[k]));
        end
        wait_drain();
    endtask

    initial begin
        // Reset with both requesters asserted: nothing may be granted
        cd = 1'b1;
        req0 = 1'b1; con0 = 1'b1; bci0 = 1'b0; len0 = 2'd0; opa0 = 32'd1; opb0 = 32'd2;
        req1 = 1'b1; con1 = 1'b0; bci1 = 1'b1; len1 = 2'd0; opa1 = 32'd5; opb1 = 32'd3;
        @(negedge ck);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'({done, done_id, bco}), 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_add", 32'({add_a, add_b, add_bci, add_con}), 32'd0);
        @(negedge ck);
        check("rst_gnt2", 32'({gnt1, gnt0}), 32'd0);
        @(posedge ck);
        #1;
        cd = 1'b0;

        // Both held continuously: grants alternate 0,1,0,1
        // op0: 1+2 = 3, carry 0; op1: 5-3 with carry-in 1 = 0x02, no borrow
        for (int g = 0; g < 4; g++) begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge ck);
                if (gnt0 || gnt1) seen = 1'b1;
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL rr_timeout: got no GNT required grant %0d", g);
            end else begin
                check("rr_order", 32'(gnt1), 32'(g % 2));
                if (g % 2 == 0) push_exp(1'b0, 32'h0000_0003, 1'b0, cyc + 2);
                else            push_exp(1'b1, 32'h0000_0002, 1'b1, cyc + 2);
            end
        end
        @(posedge ck);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        wait_drain();

        // Add with carry ripple out of byte 0
        do_op(1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_00FF, 32'h0000_0001,
              32'h0000_0100, 1'b0, 4'b0010);
        // Two-byte subtract with borrow
        do_op(1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001,
              32'h0000_FFFF, 1'b0, 4'b0001);
        // Single byte: upper bytes must read back as zero
        do_op(1'b0, 1'b1, 1'b0, 2'd0, 32'h1234_5680, 32'h0000_0080,
              32'h0000_0000, 1'b1, 4'b0000);

        // Abort a LEN=3 operation in RUN cycle 1 while requester 1 waits
        begin
            bit got;
            con0 = 1'b1; bci0 = 1'b0; len0 = 2'd3; opa0 = 32'h1122_3344; opb0 = 32'h0101_0101;
            req0 = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge ck);
                if (gnt0) got = 1'b1;
            end
            check("abort_gnt0", 32'(got), 32'd1);
            @(posedge ck);
            #1;
            req0 = 1'b0;
            con1 = 1'b1; bci1 = 1'b0; len1 = 2'd1; opa1 = 32'h0000_1234; opb1 = 32'h0000_0101;
            req1 = 1'b1;
            @(posedge ck);
            #1;
            cd = 1'b1;
            @(negedge ck);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_gnt", 32'({gnt1, gnt0}), 32'd0);
            @(posedge ck);
            #1;
            cd = 1'b0;
            @(negedge ck);
            check("abort_idle", 32'(busy), 32'd0);
            check("abort_res", res, 32'd0);
            check("abort_bco_id", 32'({bco, done_id}), 32'd0);
            check("abort_gnt1", 32'(gnt1), 32'd1);
            if (gnt1) push_exp(1'b1, 32'h0000_1335, 1'b0, cyc + 3);
            @(posedge ck);
            #1;
            req1 = 1'b0;
            wait_drain();
        end

        repeat (3) @(posedge ck);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fadsu_seq.md
FADSU_SEQ -- requirements
Module: fadsu_seq

Interface
REQ-001 SHALL have ports: CK in 1 clock (rising edge); CD in 1 reset, synchronous and active-high.
REQ-002 SHALL have per requester n in {0,1}: REQn in 1 request (level, held until GNTn); CONn in 1 op (1=add, 0=subtract); BCIn in 1 initial carry-in; LENn in 2 byte count minus 1; OPAn, OPBn in 32 operands; GNTn out 1 one-cycle accept pulse.
REQ-003 SHALL drive the external 8-bit add/sub cell: ADD_A out 8, ADD_B out 8, ADD_BCI out 1, ADD_CON out 1; and receive ADD_S in 8, ADD_BCO in 1 (combinational return, same cycle).
REQ-004 SHALL have result ports: BUSY out 1 (not IDLE); DONE out 1 one-cycle pulse; DONE_ID out 1 (granted requester); RES out 32; BCO out 1 final carry-out.

Function
REQ-005 SHALL implement states IDLE, RUN, FIN; IDLE->RUN on grant; RUN->FIN after last byte; FIN->IDLE unconditionally.
REQ-006 SHALL grant only in IDLE, at most one GNT per cycle, and latch CON, BCI, LEN, OPA, OPB of the winner in the grant cycle.
REQ-007 SHALL arbitrate round-robin: after reset, requester 0 wins a tie; after any grant, the other requester wins the next tie; a lone requester always wins.
REQ-008 SHALL process byte k (k = 0..LEN, LSB first) in RUN cycle k: ADD_A=OPA[8k+7:8k], ADD_B=OPB[8k+7:8k], ADD_CON=latched CON, ADD_BCI = latched BCI for k=0, else registered ADD_BCO of byte k-1.
REQ-009 SHALL capture ADD_S into RES[8k+7:8k] at the end of RUN cycle k and register ADD_BCO.
REQ-010 SHALL clear all RES bytes above LEN at grant.
REQ-011 SHALL assert DONE, DONE_ID, and BCO = last captured ADD_BCO in FIN; latency grant cycle T -> DONE at T+LEN+2.
REQ-012 SHALL hold RES, BCO, DONE_ID stable from FIN until the next FIN.
REQ-013 SHALL drive ADD_A, ADD_B, ADD_BCI, ADD_CON to 0 outside RUN.
REQ-014 SHALL ignore REQ changes, and operand changes after the grant cycle, while BUSY.
REQ-015 SHALL not depend on the cell's arithmetic; the bench cell model is add: A+B+BCI; subtract: A+~B+BCI (BCO=1 means no borrow).

Reset
REQ-016 CD SHALL, at the clock edge where it is high: state=IDLE; GNTn, BUSY, DONE, DONE_ID, BCO, RES, carry reg = 0; RR pointer favours 0.
REQ-017 CD asserted during RUN or FIN SHALL abort the operation with no DONE and no GNT in that cycle.

Structure
REQ-018 SHALL place in package fadsu_seq_pkg: state enum, NBYTES=4, LEN width 2, WORD=32.
REQ-019 SHALL use a single sub-module rr_arb2 (2-way round-robin arbiter with grant-enable input); byte index counter and datapath registers stay in fadsu_seq.

Verification
REQ-020 Reset: CD high 2 cycles with REQ0=REQ1=1 -> no GNT; all outputs 0; BUSY=0.
REQ-021 REQ0 add, LEN=3, OPA=0x000000FF, OPB=0x00000001, BCI0=0 -> GNT0 at T; ADD_BCI 0,1,0,0; DONE at T+5; RES=0x00000100; BCO=0; DONE_ID=0.
REQ-022 REQ1 subtract, LEN=1, OPA=0x00000000, OPB=0x00000001, BCI1=1 -> RES=0x0000FFFF; BCO=0; DONE at T+3; DONE_ID=1.
REQ-023 REQ0 add, LEN=0, OPA=0x12345680, OPB=0x00000080, BCI0=0 -> RES=0x00000000; BCO=1; DONE at T+2.
REQ-024 REQ0 and REQ1 held high continuously from reset -> grant order 0,1,0,1; each GNT only in IDLE; never two GNTs in one cycle.
REQ-025 CD pulsed during RUN cycle 1 of a LEN=3 operation -> no DONE; next cycle IDLE; RES=0; a waiting REQ1 is granted one cycle after CD deasserts.
